// File: rtl/ps2_key_ascii.sv
// PS/2 keyboard front-end: receives Set-2 scan-code frames from the raw
// ps2_clk/ps2_data lines, tracks make/break/extended prefixes and presents
// the ASCII code of the key currently held down.
module ps2_key_ascii #(
  parameter logic [7:0] RELEASE_CODE   = 8'h00,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic [7:0] scan_code,
  output logic       key_down,
  output logic       new_key,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_buf;
  logic [TW-1:0] timer;
  logic          byte_valid;
  logic          brk_flag;
  logic          ext_flag;
  logic          map_hit;
  logic [7:0]    map_ascii;

  // Bring the asynchronous PS/2 lines into the clk domain; idle level is high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall = clk_sync[2] & ~clk_sync[1];

  // Shift in frame bits on each ps2_clk falling edge, validate on the stop
  // bit and abandon a partial frame when the keyboard goes quiet too long.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt    <= 4'd0;
      frame_buf  <= 10'd0;
      timer      <= '0;
      scan_code  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        timer <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (!frame_buf[0] && data_sync[1] && (^frame_buf[9:1])) begin
            scan_code  <= frame_buf[8:1];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          frame_buf <= {data_sync[1], frame_buf[9:1]};
          bit_cnt   <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timer     <= '0;
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  // Scan-code to lowercase ASCII lookup; unmapped codes report no hit.
  always_comb begin
    map_hit   = 1'b1;
    map_ascii = 8'h00;
    case (scan_code)
      8'h1C: map_ascii = 8'h61;  8'h32: map_ascii = 8'h62;
      8'h21: map_ascii = 8'h63;  8'h23: map_ascii = 8'h64;
      8'h24: map_ascii = 8'h65;  8'h2B: map_ascii = 8'h66;
      8'h34: map_ascii = 8'h67;  8'h33: map_ascii = 8'h68;
      8'h43: map_ascii = 8'h69;  8'h3B: map_ascii = 8'h6A;
      8'h42: map_ascii = 8'h6B;  8'h4B: map_ascii = 8'h6C;
      8'h3A: map_ascii = 8'h6D;  8'h31: map_ascii = 8'h6E;
      8'h44: map_ascii = 8'h6F;  8'h4D: map_ascii = 8'h70;
      8'h15: map_ascii = 8'h71;  8'h2D: map_ascii = 8'h72;
      8'h1B: map_ascii = 8'h73;  8'h2C: map_ascii = 8'h74;
      8'h3C: map_ascii = 8'h75;  8'h2A: map_ascii = 8'h76;
      8'h1D: map_ascii = 8'h77;  8'h22: map_ascii = 8'h78;
      8'h35: map_ascii = 8'h79;  8'h1A: map_ascii = 8'h7A;
      8'h45: map_ascii = 8'h30;  8'h16: map_ascii = 8'h31;
      8'h1E: map_ascii = 8'h32;  8'h26: map_ascii = 8'h33;
      8'h25: map_ascii = 8'h34;  8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36;  8'h3D: map_ascii = 8'h37;
      8'h3E: map_ascii = 8'h38;  8'h46: map_ascii = 8'h39;
      8'h5A: map_ascii = 8'h0D;  8'h29: map_ascii = 8'h20;
      default: map_hit = 1'b0;
    endcase
  end

  // Interpret each received byte the cycle after it lands in scan_code:
  // prefixes set flags, breaks release the held key, makes press a key.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ascii    <= RELEASE_CODE;
      key_down <= 1'b0;
      new_key  <= 1'b0;
      brk_flag <= 1'b0;
      ext_flag <= 1'b0;
    end else begin
      new_key <= 1'b0;
      if (byte_valid) begin
        if (scan_code == 8'hF0) begin
          brk_flag <= 1'b1;
        end else if (scan_code == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (ext_flag) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else if (brk_flag) begin
          brk_flag <= 1'b0;
          if (map_hit && key_down && (map_ascii == ascii)) begin
            ascii    <= RELEASE_CODE;
            key_down <= 1'b0;
          end
        end else if (map_hit && ((map_ascii != ascii) || !key_down)) begin
          ascii    <= map_ascii;
          key_down <= 1'b1;
          new_key  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ascii.sv
// Directed self-checking bench for ps2_key_ascii. The PS/2 clock is run much
// faster than a real keyboard so the whole sequence stays short.
module tb_ps2_key_ascii;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ascii;
  logic [7:0] scan_code;
  logic       key_down;
  logic       new_key;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int new_key_total = 0;
  int frame_err_total = 0;
  int base_new;
  int base_err;

  ps2_key_ascii #(
    .RELEASE_CODE(8'h00),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ascii(ascii),
    .scan_code(scan_code),
    .key_down(key_down),
    .new_key(new_key),
    .frame_err(frame_err)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  // Tally the one-cycle pulses so each step can check how many occurred.
  always @(negedge clk) begin
    if (new_key) new_key_total <= new_key_total + 1;
    if (frame_err) frame_err_total <= frame_err_total + 1;
  end

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_count(input string tag, input int observed, input int expected);
    checks++;
    assert (observed == expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Send the first nbits of a frame (start, data LSB-first, parity, stop).
  task automatic apply_stimulus(input logic [7:0] data, input bit flip_parity,
                                input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^data) ^ flip_parity, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] data);
    apply_stimulus(data, 1'b0, 11);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_ascii", ascii, 8'h00);
    check_output("reset_scan", scan_code, 8'h00);
    check_output("reset_key_down", {7'd0, key_down}, 8'h00);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    check_output("idle_new_key", {7'd0, new_key}, 8'h00);
    check_output("idle_frame_err", {7'd0, frame_err}, 8'h00);

    // Press 'a'.
    base_new = new_key_total;
    send(8'h1C);
    check_output("a_scan", scan_code, 8'h1C);
    check_output("a_ascii", ascii, 8'h61);
    check_output("a_key_down", {7'd0, key_down}, 8'h01);
    check_count("a_new_key_pulses", new_key_total - base_new, 1);

    // Release 'a'.
    base_new = new_key_total;
    send(8'hF0);
    send(8'h1C);
    check_output("rel_ascii", ascii, 8'h00);
    check_output("rel_key_down", {7'd0, key_down}, 8'h00);
    check_count("rel_new_key_pulses", new_key_total - base_new, 0);

    // Enter with typematic repeats.
    base_new = new_key_total;
    send(8'h5A);
    check_output("enter_first_ascii", ascii, 8'h0D);
    send(8'h5A);
    send(8'h5A);
    check_output("enter_ascii", ascii, 8'h0D);
    check_count("enter_new_key_pulses", new_key_total - base_new, 1);

    // Parity error on 0x16.
    base_err = frame_err_total;
    base_new = new_key_total;
    apply_stimulus(8'h16, 1'b1, 11);
    check_count("parity_err_pulses", frame_err_total - base_err, 1);
    check_output("parity_ascii", ascii, 8'h0D);
    check_output("parity_scan", scan_code, 8'h5A);
    check_count("parity_new_key_pulses", new_key_total - base_new, 0);

    // Partial frame followed by a timeout, then a clean frame.
    base_err = frame_err_total;
    apply_stimulus(8'h45, 1'b0, 6);
    repeat (150) @(negedge clk);
    check_count("timeout_err_pulses", frame_err_total - base_err, 1);
    check_output("timeout_ascii", ascii, 8'h0D);
    base_new = new_key_total;
    send(8'h45);
    check_output("after_timeout_scan", scan_code, 8'h45);
    check_output("after_timeout_ascii", ascii, 8'h30);
    check_count("after_timeout_new_key", new_key_total - base_new, 1);

    // Extended key is ignored.
    base_new = new_key_total;
    send(8'hE0);
    send(8'h75);
    check_output("ext_ascii", ascii, 8'h30);
    check_output("ext_key_down", {7'd0, key_down}, 8'h01);
    check_count("ext_new_key", new_key_total - base_new, 0);

    // Hold Enter, then press 'a' on top of it.
    send(8'h5A);
    check_output("hold_enter_ascii", ascii, 8'h0D);
    base_new = new_key_total;
    send(8'h1C);
    check_output("replace_ascii", ascii, 8'h61);
    check_count("replace_new_key", new_key_total - base_new, 1);

    // Space, then a break of a key that is not held.
    send(8'h29);
    check_output("space_ascii", ascii, 8'h20);
    send(8'hF0);
    send(8'h5A);
    check_output("stray_break_ascii", ascii, 8'h20);
    check_output("stray_break_key_down", {7'd0, key_down}, 8'h01);

    // Reset in the middle of a frame.
    apply_stimulus(8'h1C, 1'b0, 4);
    #3 clrn = 1'b0;
    #1;
    check_output("midreset_ascii", ascii, 8'h00);
    check_output("midreset_scan", scan_code, 8'h00);
    check_output("midreset_key_down", {7'd0, key_down}, 8'h00);
    check_output("midreset_new_key", {7'd0, new_key}, 8'h00);
    check_output("midreset_frame_err", {7'd0, frame_err}, 8'h00);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    base_err = frame_err_total;
    send(8'h1C);
    check_output("post_reset_ascii", ascii, 8'h61);
    check_output("post_reset_scan", scan_code, 8'h1C);
    check_count("post_reset_frame_err", frame_err_total - base_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
